diy_mole_recorder: RTL

DIY_MOLE_RECORDER -- requirements
Module: diy_mole_recorder

---
 rtl/diy_mole_recorder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/diy_mole_recorder.sv
// DIY mole recorder: captures stomp timestamps (music addresses) and replays them as mole requests.
// Optional build macro RECORDER_QUANTIZE_EN stores and compares addresses with bits [7:0] cleared.
module diy_mole_recorder #(
  parameter int DEPTH = 16,
  parameter int AW    = 23
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     record_en,
  input  logic                     play_en,
  input  logic                     stomp,
  input  logic [AW-1:0]            music_address,
  output logic                     request_mole,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     recording,
  output logic                     full,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RECORD, PLAY, MOLE} state_t;

  state_t        state;
  logic [AW-1:0] mem [DEPTH];
  logic [AW-1:0] last_addr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          stomp_p1;

  logic          stomp_edge;
  logic [AW-1:0] addr_q;
  logic          addr_newer;
  logic          wr_fire;
  logic          play_hit;
  logic          rd_wrap;

  function automatic logic [AW-1:0] quantize(input logic [AW-1:0] a);
`ifdef RECORDER_QUANTIZE_EN
    quantize = {a[AW-1:8], 8'h00};
`else
    quantize = a;
`endif
  endfunction

  // Both sides of every compare are quantized, so equality and ordering ignore the low byte when enabled.
  always_comb begin
    stomp_edge = stomp & ~stomp_p1;
    addr_q     = quantize(music_address);
    addr_newer = (count == '0) || (addr_q > last_addr);
    wr_fire    = (state == RECORD) && record_en && stomp_edge && (count != CNT_FULL) && addr_newer;
    play_hit   = (addr_q == mem[rd_ptr]);
    rd_wrap    = (({1'b0, rd_ptr} + (PW+1)'(1)) == count);
  end

  assign request_mole = (state == MOLE);
  assign recording    = (state == RECORD);
  assign full         = (count == CNT_FULL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      stomp_p1 <= 1'b0;
    end else begin
      stomp_p1 <= stomp;
      if (record_en && (state != RECORD)) begin
        state    <= RECORD;
        count    <= '0;
        wr_ptr   <= '0;
        overflow <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (play_en && (count != '0)) begin
              state  <= PLAY;
              rd_ptr <= '0;
            end
          end
          RECORD: begin
            if (!record_en) begin
              state <= IDLE;
            end else if (stomp_edge) begin
              if (count == CNT_FULL) begin
                overflow <= 1'b1;
              end else if (addr_newer) begin
                count  <= count + (PW+1)'(1);
                wr_ptr <= wr_ptr + PW'(1);
              end
            end
          end
          PLAY: begin
            if (!play_en) begin
              state  <= IDLE;
              rd_ptr <= '0;
            end else if (play_hit) begin
              state  <= MOLE;
              rd_ptr <= rd_wrap ? '0 : rd_ptr + PW'(1);
            end
          end
          MOLE: begin
            if (!play_en) begin
              state  <= IDLE;
              rd_ptr <= '0;
            end else begin
              state <= PLAY;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= addr_q;
      last_addr   <= addr_q;
    end
  end

endmodule
